// File: rtl/fdiv_seq_if.sv
// Request/result bundle for the sequential binary32 divider.
interface fdiv_seq_if;
  logic        start;
  logic [31:0] x1;
  logic [31:0] x2;
  logic        ready;
  logic        valid;
  logic [31:0] y;
  logic        ovf;
  logic        dz;

  modport master (output start, x1, x2, input ready, valid, y, ovf, dz);
  modport slave  (input start, x1, x2, output ready, valid, y, ovf, dz);
endinterface

// File: rtl/fdiv_seq.sv
// Sequential IEEE-754 binary32 divider: restoring mantissa division, one
// quotient bit per cycle, round-half-up, flush-to-zero, fixed latency.
module fdiv_seq (
  input logic       clk,
  input logic       rst,
  fdiv_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, DIV, ROUND} state_t;
  typedef enum logic [2:0] {SP_NONE, SP_NAN, SP_INF, SP_DZ, SP_ZERO} special_t;

  state_t      state, state_nx;
  special_t    special, cap_special;
  logic [4:0]  cnt;
  logic [24:0] rem;
  logic [23:0] dvsr;
  logic [25:0] q;
  logic [9:0]  exp_base, cap_exp;
  logic        sign;

  logic [7:0]  ea, eb;
  logic [22:0] fa, fb;
  logic [23:0] ma, mb, na, nb;
  logic [4:0]  lza, lzb;
  logic [9:0]  eae, ebe;
  logic        nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;

  logic [23:0] mant, mant_r;
  logic        guard;
  logic [24:0] sum;
  logic [9:0]  e1, e2;
  logic [31:0] y_nx;
  logic        ovf_nx, dz_nx;

  // Counts leading zeros by shifting until the MSB is set; 24 for zero input.
  function automatic logic [4:0] lzc24(input logic [23:0] m);
    logic [4:0]  n;
    logic [23:0] t;
    n = '0;
    t = m;
    for (int unsigned i = 0; i < 24; i++) begin
      if (!t[23]) begin
        n = n + 5'd1;
        t = t << 1;
      end
    end
    return n;
  endfunction

  // Operand preparation and special-case classification at capture.
  always_comb begin
    ea     = bus.x1[30:23];
    eb     = bus.x2[30:23];
    fa     = bus.x1[22:0];
    fb     = bus.x2[22:0];
    ma     = {|ea, fa};
    mb     = {|eb, fb};
    lza    = lzc24(ma);
    lzb    = lzc24(mb);
    na     = ma << lza;
    nb     = mb << lzb;
    eae    = (ea == 8'd0) ? 10'd1 : {2'b00, ea};
    ebe    = (eb == 8'd0) ? 10'd1 : {2'b00, eb};
    cap_exp = eae - {5'b0, lza} - ebe + {5'b0, lzb} + 10'd127;
    nan_a  = (&ea) & (|fa);
    nan_b  = (&eb) & (|fb);
    inf_a  = (&ea) & ~(|fa);
    inf_b  = (&eb) & ~(|fb);
    zero_a = ~(|ea) & ~(|fa);
    zero_b = ~(|eb) & ~(|fb);
    if (nan_a | nan_b | (zero_a & zero_b) | (inf_a & inf_b))
      cap_special = SP_NAN;
    else if (inf_a)
      cap_special = SP_INF;
    else if (zero_b)
      cap_special = SP_DZ;
    else if (zero_a | inf_b)
      cap_special = SP_ZERO;
    else
      cap_special = SP_NONE;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start) state_nx = DIV;
      DIV:     if (cnt == 5'd25) state_nx = ROUND;
      ROUND:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.ready = (state == IDLE);
  end

  // Normalisation, round-half-up and result packing from the finished quotient.
  always_comb begin
    if (q[25]) begin
      mant  = q[25:2];
      guard = q[1];
      e1    = exp_base;
    end else begin
      mant  = q[24:1];
      guard = q[0];
      e1    = exp_base - 10'd1;
    end
    sum = {1'b0, mant} + {24'b0, guard};
    if (sum[24]) begin
      mant_r = sum[24:1];
      e2     = e1 + 10'd1;
    end else begin
      mant_r = sum[23:0];
      e2     = e1;
    end
    ovf_nx = 1'b0;
    dz_nx  = 1'b0;
    case (special)
      SP_NAN:  y_nx = 32'h7FC0_0000;
      SP_INF:  y_nx = {sign, 8'hFF, 23'b0};
      SP_DZ: begin
        y_nx  = {sign, 8'hFF, 23'b0};
        dz_nx = 1'b1;
      end
      SP_ZERO: y_nx = {sign, 31'b0};
      default: begin
        if ($signed(e2) >= 10'sd255) begin
          y_nx   = {sign, 8'hFF, 23'b0};
          ovf_nx = 1'b1;
        end else if ($signed(e2) <= 10'sd0)
          y_nx = {sign, 31'b0};
        else
          y_nx = {sign, e2[7:0], mant_r[22:0]};
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      rem       <= '0;
      dvsr      <= '0;
      q         <= '0;
      exp_base  <= '0;
      sign      <= 1'b0;
      special   <= SP_NONE;
      bus.y     <= '0;
      bus.ovf   <= 1'b0;
      bus.dz    <= 1'b0;
      bus.valid <= 1'b0;
    end else begin
      bus.valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            rem      <= {1'b0, na};
            dvsr     <= nb;
            q        <= '0;
            cnt      <= '0;
            exp_base <= cap_exp;
            sign     <= bus.x1[31] ^ bus.x2[31];
            special  <= cap_special;
          end
        end
        DIV: begin
          if (rem >= {1'b0, dvsr}) begin
            rem <= (rem - {1'b0, dvsr}) << 1;
            q   <= {q[24:0], 1'b1};
          end else begin
            rem <= rem << 1;
            q   <= {q[24:0], 1'b0};
          end
          cnt <= cnt + 5'd1;
        end
        ROUND: begin
          bus.valid <= 1'b1;
          bus.y     <= y_nx;
          bus.ovf   <= ovf_nx;
          bus.dz    <= dz_nx;
          cnt       <= '0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fdiv_seq.sv
// Bench for fdiv_seq: directed corner cases, control scenarios and random
// operands checked against an arithmetic reference model.
module tb_fdiv_seq;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  fdiv_seq_if bus ();

  fdiv_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Quotient bits from integer division of the scaled normalized mantissas.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] y, output logic ovf, output logic dz);
    int     ea, eb, e;
    longint ma, mb, qq, mant, g;
    logic   s;
    bit     nan_a, nan_b, inf_a, inf_b, z_a, z_b;
    logic [31:0] ev;
    logic [63:0] mv;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    ma = longint'(a[22:0]);
    mb = longint'(b[22:0]);
    s  = a[31] ^ b[31];
    nan_a = (ea == 255) && (ma != 0);
    nan_b = (eb == 255) && (mb != 0);
    inf_a = (ea == 255) && (ma == 0);
    inf_b = (eb == 255) && (mb == 0);
    z_a   = (ea == 0) && (ma == 0);
    z_b   = (eb == 0) && (mb == 0);
    ovf = 1'b0;
    dz  = 1'b0;
    if (nan_a || nan_b || (z_a && z_b) || (inf_a && inf_b)) y = 32'h7FC0_0000;
    else if (inf_a) y = {s, 8'hFF, 23'h0};
    else if (z_b) begin
      y  = {s, 8'hFF, 23'h0};
      dz = 1'b1;
    end
    else if (z_a || inf_b) y = {s, 31'h0};
    else begin
      if (ea == 0) ea = 1; else ma = ma + (64'sd1 << 23);
      if (eb == 0) eb = 1; else mb = mb + (64'sd1 << 23);
      while (ma < (64'sd1 << 23)) begin ma = ma * 2; ea = ea - 1; end
      while (mb < (64'sd1 << 23)) begin mb = mb * 2; eb = eb - 1; end
      qq = (ma * (64'sd1 << 25)) / mb;
      e  = ea - eb + 127;
      if (qq >= (64'sd1 << 25)) begin
        mant = qq / 4;
        g    = (qq / 2) % 2;
      end else begin
        mant = qq / 2;
        g    = qq % 2;
        e    = e - 1;
      end
      mant = mant + g;
      if (mant >= (64'sd1 << 24)) begin
        mant = mant / 2;
        e    = e + 1;
      end
      ev = e;
      mv = mant;
      if (e >= 255) begin
        y   = {s, 8'hFF, 23'h0};
        ovf = 1'b1;
      end
      else if (e <= 0) y = {s, 31'h0};
      else y = {s, ev[7:0], mv[22:0]};
    end
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [31:0] v;
    v = $urandom();
    case ($urandom_range(0, 9))
      0: v[30:0]  = '0;
      1: v[30:23] = 8'hFF;
      2: begin v[30:23] = 8'hFF; v[22:0] = '0; end
      3: v[30:23] = '0;
      4: v[30:23] = 8'($urandom_range(1, 10));
      5: v[30:23] = 8'($urandom_range(245, 254));
      default: v[30:23] = 8'($urandom_range(100, 154));
    endcase
    return v;
  endfunction

  // Drives a start so that the next rising edge is the capture edge, then
  // scrambles the operands to show they are no longer observed.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    check("ready_before_start", {31'b0, bus.ready}, 32'd1);
    bus.x1    = a;
    bus.x2    = b;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.x1    = $urandom();
    bus.x2    = $urandom();
  endtask

  // Counts negedges until valid; the negedge following edge N+k is number k+1.
  task automatic wait_valid(input int unsigned limit, output int unsigned n, output bit seen);
    n    = 0;
    seen = 1'b0;
    while (!seen && n < limit) begin
      @(negedge clk);
      n++;
      if (bus.valid) seen = 1'b1;
    end
  endtask

  task automatic check_result(input string tag, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ey;
    logic        eo, ed;
    ref_div(a, b, ey, eo, ed);
    check({tag, ".y"}, bus.y, ey);
    check({tag, ".ovf"}, {31'b0, bus.ovf}, {31'b0, eo});
    check({tag, ".dz"}, {31'b0, bus.dz}, {31'b0, ed});
    check({tag, ".ready"}, {31'b0, bus.ready}, 32'd1);
  endtask

  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b);
    int unsigned n;
    bit          seen;
    start_op(a, b);
    wait_valid(40, n, seen);
    check({tag, ".latency"}, n, 32'd28);
    check_result(tag, a, b);
    @(negedge clk);
    check({tag, ".pulse"}, {31'b0, bus.valid}, 32'd0);
  endtask

  initial begin
    int unsigned n, pulses;
    bit          seen;
    logic [31:0] ra, rb;

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.x1    = '0;
    bus.x2    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst.ready", {31'b0, bus.ready}, 32'd1);
    check("rst.valid", {31'b0, bus.valid}, 32'd0);
    check("rst.y", bus.y, 32'd0);
    check("rst.ovf", {31'b0, bus.ovf}, 32'd0);
    check("rst.dz", {31'b0, bus.dz}, 32'd0);
    rst = 1'b0;

    do_op("3div2", 32'h4040_0000, 32'h4000_0000);
    check("3div2.const", bus.y, 32'h3FC0_0000);
    do_op("1div3", 32'h3F80_0000, 32'h4040_0000);
    check("1div3.const", bus.y, 32'h3EAA_AAAB);
    do_op("1div0", 32'h3F80_0000, 32'h0000_0000);
    check("1div0.const", bus.y, 32'h7F80_0000);
    check("1div0.dzconst", {31'b0, bus.dz}, 32'd1);
    do_op("0div0", 32'h0000_0000, 32'h0000_0000);
    check("0div0.const", bus.y, 32'h7FC0_0000);
    do_op("maxdivhalf", 32'h7F7F_FFFF, 32'h3F00_0000);
    check("maxdivhalf.const", bus.y, 32'h7F80_0000);
    check("maxdivhalf.ovfconst", {31'b0, bus.ovf}, 32'd1);
    do_op("subnorm", 32'h0040_0000, 32'h0080_0000);
    check("subnorm.const", bus.y, 32'h3F00_0000);
    do_op("infdivneg", 32'h7F80_0000, 32'hC000_0000);
    do_op("negdivinf", 32'hC000_0000, 32'h7F80_0000);
    do_op("nandiv", 32'h7FA0_0001, 32'h3F80_0000);
    do_op("tinydiv", 32'h0080_0000, 32'h7F00_0000);

    // A start pulsed while busy must be dropped.
    start_op(32'h4040_0000, 32'h4000_0000);
    repeat (5) @(negedge clk);
    bus.x1    = 32'h4120_0000;
    bus.x2    = 32'h3F80_0000;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_valid(40, n, seen);
    check("ignore.latency", n, 32'd23);
    check_result("ignore", 32'h4040_0000, 32'h4000_0000);
    pulses = 0;
    repeat (35) begin
      @(negedge clk);
      if (bus.valid) pulses++;
    end
    check("ignore.extra_pulses", pulses, 32'd0);

    // Reset in mid-operation aborts it silently.
    start_op(32'h3F80_0000, 32'h4040_0000);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort.ready", {31'b0, bus.ready}, 32'd1);
    check("abort.y", bus.y, 32'd0);
    check("abort.valid", {31'b0, bus.valid}, 32'd0);
    pulses = 0;
    repeat (35) begin
      @(negedge clk);
      if (bus.valid) pulses++;
    end
    check("abort.pulses", pulses, 32'd0);
    do_op("after_abort", 32'h4040_0000, 32'h4000_0000);

    // Back-to-back: restart at the edge right after the valid cycle begins.
    start_op(32'h3F80_0000, 32'h4040_0000);
    wait_valid(40, n, seen);
    check("b2b1.latency", n, 32'd28);
    check_result("b2b1", 32'h3F80_0000, 32'h4040_0000);
    bus.x1    = 32'hC0A0_0000;
    bus.x2    = 32'h4000_0000;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_valid(40, n, seen);
    check("b2b2.latency", n, 32'd28);
    check_result("b2b2", 32'hC0A0_0000, 32'h4000_0000);

    for (int i = 0; i < 150; i++) begin
      ra = rand_fp();
      rb = rand_fp();
      do_op($sformatf("rand%0d", i), ra, rb);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
